writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Architectural register file and scoreboard that consumes the two dequeue ports of the writeback FIFO.
- Holds 32 x 16-bit general registers and a 2-bit status register.
- Each register has a busy bit. The issue stage sets a busy bit when it allocates that register as a destination; a writeback to the register clears it.
- Provides four synchronous read ports (two operands for each of two issue slots) with write-first bypass, so issue sees fresh data and busy state.

Parameters:
NUM_REGS, 32, number of general registers (address width fixed at 5)
DATA_WIDTH, 16, register data width

Ports:
clock_i  in  1  clock, all state updates on rising edge
reset_i  in  1  synchronous active-high reset
enableA_i  in  1  writeback port A valid
AddressA_i  in  5  writeback A destination register
DataA_i  in  16  writeback A data
statusA_i  in  2  writeback A status
enableB_i  in  1  writeback port B valid (B is younger than A)
AddressB_i  in  5  writeback B destination register
DataB_i  in  16  writeback B data
statusB_i  in  2  writeback B status
allocA_i  in  1  issue slot A marks a destination busy
allocAddrA_i  in  5  slot A destination
allocB_i  in  1  issue slot B marks a destination busy
allocAddrB_i  in  5  slot B destination
readAddr0_i..readAddr3_i  in  5 each  read addresses (0,1 = slot A operands; 2,3 = slot B operands)
readData0_o..readData3_o  out  16 each  registered read data
readBusy0_o..readBusy3_o  out  1 each  registered busy bit of the addressed register
status_o  out  2  current status register
busyAny_o  out  1  OR of all busy bits
wbCount_o  out  8  count of accepted writebacks, wrapping

Behaviour:
- Reset (reset_i=1 at an edge):
  - All registers, busy bits, status_o, read outputs, readBusy outputs and wbCount_o go to 0.
  - Reset overrides every same-cycle write, alloc and read.
  - Reset mid-stream discards in-flight writebacks and allocs presented that cycle.
- Writes:
  - On an edge with enableA_i, Reg[AddressA_i] takes DataA_i; likewise for port B.
  - If both ports are enabled and AddressA_i==AddressB_i, port B wins: its data is written and it is the port bypassed to reads.
- Status:
  - If enableB_i, status takes statusB_i; else if enableA_i, status takes statusA_i; else it holds.
  - status_o is the register output, so it updates one cycle after the writeback.
- Busy:
  - A writeback clears busy[addr]; an alloc sets busy[addr].
  - If an alloc and a writeback hit the same register in the same cycle, set wins (a new producer is outstanding).
  - If allocA and allocB name the same register, it is set once.
  - Alloc of an already-busy register leaves it set.
  - No busy check on writeback: a writeback to a non-busy register still writes data.
- Reads (latency 1):
  - readDataN_o and readBusyN_o are registered. The value presented at edge k reflects state after the edge-k updates (write-first bypass).
  - readData bypass priority: port B write, then port A write, then stored value.
  - readBusy uses the same set-over-clear rule as the busy update.
- busyAny_o is combinational from the busy register.
- wbCount_o:
  - Increments by enableA_i+enableB_i (0, 1 or 2) per cycle, modulo 256.
  - 255+2 wraps to 1.
- No stalls, no backpressure: both writeback ports are always accepted.

Test Plan:
- Reset, then read all four ports at addr 0 -> readData=0x0000, readBusy=0, status_o=0, busyAny_o=0, wbCount_o=0.
- enableA on r3=0x1234 and enableB on r7=0xBEEF (statusB=2), while reading r3 and r7 the same cycle -> next cycle readData=0x1234 and 0xBEEF (bypass); status_o=2; wbCount_o=2.
- Both ports write r5 (A=0x1111, B=0x2222) -> r5 reads 0x2222 on bypass and on later re-read.
- allocA r9 -> busyAny_o=1, readBusy(r9)=1. Next cycle writeback r9 and allocB r9 together -> busy remains 1, data updated. A further writeback r9 alone -> busy 0, busyAny_o=0.
- Drive 129 cycles of dual writebacks from reset -> wbCount_o wraps to 2.
- Writes to r1 and an alloc on r2 on the same edge as reset_i=1 -> r1 reads 0, r2 not busy, wbCount_o=0.

Source files
------------

// File: rtl/writeback_regfile.sv
// Architectural register file plus busy scoreboard, fed by the two writeback FIFO dequeue ports.
// Four registered read ports see same-edge writes and busy updates (write-first bypass).
module writeback_regfile #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enableA_i,
    input  logic [4:0]            AddressA_i,
    input  logic [DATA_WIDTH-1:0] DataA_i,
    input  logic [1:0]            statusA_i,
    input  logic                  enableB_i,
    input  logic [4:0]            AddressB_i,
    input  logic [DATA_WIDTH-1:0] DataB_i,
    input  logic [1:0]            statusB_i,
    input  logic                  allocA_i,
    input  logic [4:0]            allocAddrA_i,
    input  logic                  allocB_i,
    input  logic [4:0]            allocAddrB_i,
    input  logic [4:0]            readAddr0_i,
    input  logic [4:0]            readAddr1_i,
    input  logic [4:0]            readAddr2_i,
    input  logic [4:0]            readAddr3_i,
    output logic [DATA_WIDTH-1:0] readData0_o,
    output logic [DATA_WIDTH-1:0] readData1_o,
    output logic [DATA_WIDTH-1:0] readData2_o,
    output logic [DATA_WIDTH-1:0] readData3_o,
    output logic                  readBusy0_o,
    output logic                  readBusy1_o,
    output logic                  readBusy2_o,
    output logic                  readBusy3_o,
    output logic [1:0]            status_o,
    output logic                  busyAny_o,
    output logic [7:0]            wbCount_o
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   clr_mask;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   busy_next;
    logic [1:0]            status_q;
    logic [7:0]            wb_count;

    logic [4:0]            raddr   [4];
    logic [DATA_WIDTH-1:0] rd_next [4];
    logic                  rb_next [4];
    logic [DATA_WIDTH-1:0] rd_q    [4];
    logic                  rb_q    [4];

    assign raddr[0] = readAddr0_i;
    assign raddr[1] = readAddr1_i;
    assign raddr[2] = readAddr2_i;
    assign raddr[3] = readAddr3_i;

    // Set is applied after clear so a same-edge alloc keeps the register busy.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (enableA_i) clr_mask[AddressA_i] = 1'b1;
        if (enableB_i) clr_mask[AddressB_i] = 1'b1;
        if (allocA_i)  set_mask[allocAddrA_i] = 1'b1;
        if (allocB_i)  set_mask[allocAddrB_i] = 1'b1;
        busy_next = (busy & ~clr_mask) | set_mask;
    end

    always_comb begin
        for (int unsigned p = 0; p < 4; p++) begin
            if (enableB_i && (AddressB_i == raddr[p]))
                rd_next[p] = DataB_i;
            else if (enableA_i && (AddressA_i == raddr[p]))
                rd_next[p] = DataA_i;
            else
                rd_next[p] = regs[raddr[p]];
            rb_next[p] = busy_next[raddr[p]];
        end
    end

    // Port B is written last so it wins an address collision with port A.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            if (enableA_i) regs[AddressA_i] <= DataA_i;
            if (enableB_i) regs[AddressB_i] <= DataB_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy     <= '0;
            status_q <= '0;
            wb_count <= '0;
        end else begin
            busy     <= busy_next;
            wb_count <= wb_count + 8'(enableA_i) + 8'(enableB_i);
            if (enableB_i)
                status_q <= statusB_i;
            else if (enableA_i)
                status_q <= statusA_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int unsigned p = 0; p < 4; p++) begin
                rd_q[p] <= '0;
                rb_q[p] <= 1'b0;
            end
        end else begin
            for (int unsigned p = 0; p < 4; p++) begin
                rd_q[p] <= rd_next[p];
                rb_q[p] <= rb_next[p];
            end
        end
    end

    assign readData0_o = rd_q[0];
    assign readData1_o = rd_q[1];
    assign readData2_o = rd_q[2];
    assign readData3_o = rd_q[3];
    assign readBusy0_o = rb_q[0];
    assign readBusy1_o = rb_q[1];
    assign readBusy2_o = rb_q[2];
    assign readBusy3_o = rb_q[3];
    assign status_o    = status_q;
    assign busyAny_o   = |busy;
    assign wbCount_o   = wb_count;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a vector table of single-edge cases plus
// hand-written wbCount wrap sequences.
module tb_writeback_regfile;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        enableA_i, enableB_i, allocA_i, allocB_i;
    logic [4:0]  AddressA_i, AddressB_i, allocAddrA_i, allocAddrB_i;
    logic [15:0] DataA_i, DataB_i;
    logic [1:0]  statusA_i, statusB_i;
    logic [4:0]  readAddr0_i, readAddr1_i, readAddr2_i, readAddr3_i;
    logic [15:0] readData0_o, readData1_o, readData2_o, readData3_o;
    logic        readBusy0_o, readBusy1_o, readBusy2_o, readBusy3_o;
    logic [1:0]  status_o;
    logic        busyAny_o;
    logic [7:0]  wbCount_o;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        rst;
        logic        ena; logic [4:0] aa; logic [15:0] da; logic [1:0] sa;
        logic        enb; logic [4:0] ab; logic [15:0] db; logic [1:0] sb;
        logic        ala; logic [4:0] ala_addr;
        logic        alb; logic [4:0] alb_addr;
        logic [4:0]  ra [4];
        logic [15:0] rd [4];
        logic        rb [4];
        logic [1:0]  st;
        logic        ba;
        logic [7:0]  wc;
    } vec_t;

    vec_t vecs[$];

    writeback_regfile #(.NUM_REGS(32), .DATA_WIDTH(16)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .enableA_i(enableA_i), .AddressA_i(AddressA_i), .DataA_i(DataA_i), .statusA_i(statusA_i),
        .enableB_i(enableB_i), .AddressB_i(AddressB_i), .DataB_i(DataB_i), .statusB_i(statusB_i),
        .allocA_i(allocA_i), .allocAddrA_i(allocAddrA_i),
        .allocB_i(allocB_i), .allocAddrB_i(allocAddrB_i),
        .readAddr0_i(readAddr0_i), .readAddr1_i(readAddr1_i),
        .readAddr2_i(readAddr2_i), .readAddr3_i(readAddr3_i),
        .readData0_o(readData0_o), .readData1_o(readData1_o),
        .readData2_o(readData2_o), .readData3_o(readData3_o),
        .readBusy0_o(readBusy0_o), .readBusy1_o(readBusy1_o),
        .readBusy2_o(readBusy2_o), .readBusy3_o(readBusy3_o),
        .status_o(status_o), .busyAny_o(busyAny_o), .wbCount_o(wbCount_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t blank();
        vec_t t;
        t.rst = 0;
        t.ena = 0; t.aa = 0; t.da = 0; t.sa = 0;
        t.enb = 0; t.ab = 0; t.db = 0; t.sb = 0;
        t.ala = 0; t.ala_addr = 0; t.alb = 0; t.alb_addr = 0;
        for (int p = 0; p < 4; p++) begin t.ra[p] = 0; t.rd[p] = 0; t.rb[p] = 0; end
        t.st = 0; t.ba = 0; t.wc = 0;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        @(negedge clock_i);
        reset_i = t.rst;
        enableA_i = t.ena; AddressA_i = t.aa; DataA_i = t.da; statusA_i = t.sa;
        enableB_i = t.enb; AddressB_i = t.ab; DataB_i = t.db; statusB_i = t.sb;
        allocA_i = t.ala; allocAddrA_i = t.ala_addr;
        allocB_i = t.alb; allocAddrB_i = t.alb_addr;
        readAddr0_i = t.ra[0]; readAddr1_i = t.ra[1];
        readAddr2_i = t.ra[2]; readAddr3_i = t.ra[3];
        @(posedge clock_i);
        #1;
    endtask

    task automatic dual_wb(input int i);
        vec_t t;
        t = blank();
        t.ena = 1; t.aa = 5'(i);      t.da = 16'(i);          t.sa = 2'd1;
        t.enb = 1; t.ab = 5'(i + 16); t.db = 16'(i) ^ 16'hFFFF; t.sb = 2'd2;
        t.ra[0] = 5'(i); t.ra[1] = 5'(i + 16);
        drive(t);
    endtask

    initial begin
        vec_t t;
        reset_i = 1; enableA_i = 0; enableB_i = 0; allocA_i = 0; allocB_i = 0;
        AddressA_i = 0; AddressB_i = 0; DataA_i = 0; DataB_i = 0;
        statusA_i = 0; statusB_i = 0; allocAddrA_i = 0; allocAddrB_i = 0;
        readAddr0_i = 0; readAddr1_i = 0; readAddr2_i = 0; readAddr3_i = 0;

        // v0: reset state
        t = blank(); t.rst = 1; vecs.push_back(t);
        // v1: dual writeback to distinct regs with same-edge read bypass
        t = blank(); t.ena = 1; t.aa = 3; t.da = 16'h1234; t.sa = 1;
        t.enb = 1; t.ab = 7; t.db = 16'hBEEF; t.sb = 2;
        t.ra = '{3, 7, 0, 3}; t.rd = '{16'h1234, 16'hBEEF, 0, 16'h1234};
        t.st = 2; t.wc = 2; vecs.push_back(t);
        // v2: idle re-read, status holds
        t = blank(); t.ra = '{7, 3, 3, 7}; t.rd = '{16'hBEEF, 16'h1234, 16'h1234, 16'hBEEF};
        t.st = 2; t.wc = 2; vecs.push_back(t);
        // v3: both ports hit r5, B wins
        t = blank(); t.ena = 1; t.aa = 5; t.da = 16'h1111; t.sa = 1;
        t.enb = 1; t.ab = 5; t.db = 16'h2222; t.sb = 3;
        t.ra = '{5, 5, 3, 0}; t.rd = '{16'h2222, 16'h2222, 16'h1234, 0};
        t.st = 3; t.wc = 4; vecs.push_back(t);
        // v4: re-read r5 from storage
        t = blank(); t.ra = '{5, 7, 5, 3}; t.rd = '{16'h2222, 16'hBEEF, 16'h2222, 16'h1234};
        t.st = 3; t.wc = 4; vecs.push_back(t);
        // v5: A only, status from A
        t = blank(); t.ena = 1; t.aa = 6; t.da = 16'h00AA; t.sa = 1;
        t.ra = '{6, 5, 0, 6}; t.rd = '{16'h00AA, 16'h2222, 0, 16'h00AA};
        t.st = 1; t.wc = 5; vecs.push_back(t);
        // v6: alloc r9
        t = blank(); t.ala = 1; t.ala_addr = 9;
        t.ra = '{9, 3, 9, 0}; t.rd = '{0, 16'h1234, 0, 0}; t.rb = '{1, 0, 1, 0};
        t.st = 1; t.ba = 1; t.wc = 5; vecs.push_back(t);
        // v7: writeback r9 and alloc r9 together, set wins
        t = blank(); t.ena = 1; t.aa = 9; t.da = 16'h5A5A; t.sa = 0;
        t.alb = 1; t.alb_addr = 9;
        t.ra = '{9, 6, 9, 9}; t.rd = '{16'h5A5A, 16'h00AA, 16'h5A5A, 16'h5A5A}; t.rb = '{1, 0, 1, 1};
        t.st = 0; t.ba = 1; t.wc = 6; vecs.push_back(t);
        // v8: writeback r9 alone clears busy
        t = blank(); t.enb = 1; t.ab = 9; t.db = 16'h6B6B; t.sb = 2;
        t.ra = '{9, 9, 5, 9}; t.rd = '{16'h6B6B, 16'h6B6B, 16'h2222, 16'h6B6B};
        t.st = 2; t.wc = 7; vecs.push_back(t);
        // v9: both allocs name r10
        t = blank(); t.ala = 1; t.ala_addr = 10; t.alb = 1; t.alb_addr = 10;
        t.ra = '{10, 9, 10, 0}; t.rd = '{0, 16'h6B6B, 0, 0}; t.rb = '{1, 0, 1, 0};
        t.st = 2; t.ba = 1; t.wc = 7; vecs.push_back(t);
        // v10: alloc of an already-busy register
        t = blank(); t.ala = 1; t.ala_addr = 10;
        t.ra = '{10, 10, 10, 10}; t.rb = '{1, 1, 1, 1};
        t.st = 2; t.ba = 1; t.wc = 7; vecs.push_back(t);
        // v11: writeback clears r10, alloc sets r11
        t = blank(); t.ena = 1; t.aa = 10; t.da = 16'h0F0F; t.sa = 1;
        t.alb = 1; t.alb_addr = 11;
        t.ra = '{10, 11, 10, 11}; t.rd = '{16'h0F0F, 0, 16'h0F0F, 0}; t.rb = '{0, 1, 0, 1};
        t.st = 1; t.ba = 1; t.wc = 8; vecs.push_back(t);
        // v12: A and B to different regs, status from B
        t = blank(); t.ena = 1; t.aa = 12; t.da = 16'h2468; t.sa = 3;
        t.enb = 1; t.ab = 11; t.db = 16'h1357; t.sb = 0;
        t.ra = '{11, 12, 10, 0}; t.rd = '{16'h1357, 16'h2468, 16'h0F0F, 0};
        t.st = 0; t.ba = 0; t.wc = 10; vecs.push_back(t);
        // v13: writeback to non-busy top register
        t = blank(); t.ena = 1; t.aa = 31; t.da = 16'hFFFF; t.sa = 2;
        t.ra = '{31, 12, 31, 11}; t.rd = '{16'hFFFF, 16'h2468, 16'hFFFF, 16'h1357};
        t.st = 2; t.wc = 11; vecs.push_back(t);
        // v14: reset overrides same-edge writes and allocs
        t = blank(); t.rst = 1; t.ena = 1; t.aa = 1; t.da = 16'hAAAA; t.sa = 3;
        t.enb = 1; t.ab = 3; t.db = 16'h5555; t.sb = 1;
        t.ala = 1; t.ala_addr = 2; t.alb = 1; t.alb_addr = 4;
        t.ra = '{1, 2, 3, 31}; vecs.push_back(t);
        // v15: storage cleared by reset
        t = blank(); t.ra = '{1, 2, 3, 5}; vecs.push_back(t);
        // v16: fresh writeback and alloc on r20, set wins
        t = blank(); t.enb = 1; t.ab = 20; t.db = 16'h7777; t.sb = 1;
        t.ala = 1; t.ala_addr = 20;
        t.ra = '{20, 20, 2, 20}; t.rd = '{16'h7777, 16'h7777, 0, 16'h7777}; t.rb = '{1, 1, 0, 1};
        t.st = 1; t.ba = 1; t.wc = 1; vecs.push_back(t);
        // v17: later writeback clears r20
        t = blank(); t.ena = 1; t.aa = 20; t.da = 16'h8888; t.sa = 2;
        t.ra = '{20, 20, 20, 20}; t.rd = '{16'h8888, 16'h8888, 16'h8888, 16'h8888};
        t.st = 2; t.ba = 0; t.wc = 2; vecs.push_back(t);

        foreach (vecs[n]) begin
            drive(vecs[n]);
            check($sformatf("v%0d readData0", n), readData0_o, vecs[n].rd[0]);
            check($sformatf("v%0d readData1", n), readData1_o, vecs[n].rd[1]);
            check($sformatf("v%0d readData2", n), readData2_o, vecs[n].rd[2]);
            check($sformatf("v%0d readData3", n), readData3_o, vecs[n].rd[3]);
            check($sformatf("v%0d readBusy0", n), 16'(readBusy0_o), 16'(vecs[n].rb[0]));
            check($sformatf("v%0d readBusy1", n), 16'(readBusy1_o), 16'(vecs[n].rb[1]));
            check($sformatf("v%0d readBusy2", n), 16'(readBusy2_o), 16'(vecs[n].rb[2]));
            check($sformatf("v%0d readBusy3", n), 16'(readBusy3_o), 16'(vecs[n].rb[3]));
            check($sformatf("v%0d status", n),    16'(status_o),    16'(vecs[n].st));
            check($sformatf("v%0d busyAny", n),   16'(busyAny_o),   16'(vecs[n].ba));
            check($sformatf("v%0d wbCount", n),   16'(wbCount_o),   16'(vecs[n].wc));
        end

        // 129 dual writebacks from reset: 258 mod 256 = 2
        t = blank(); t.rst = 1; drive(t);
        check("wrap reset wbCount", 16'(wbCount_o), 16'd0);
        for (int i = 0; i < 129; i++) dual_wb(i);
        check("wrap129 wbCount", 16'(wbCount_o), 16'd2);
        check("wrap129 readA", readData0_o, 16'd128);
        check("wrap129 readB", readData1_o, 16'd128 ^ 16'hFFFF);
        check("wrap129 status", 16'(status_o), 16'd2);

        // 1 + 127*2 = 255, then 255 + 2 wraps to 1
        t = blank(); t.rst = 1; drive(t);
        t = blank(); t.ena = 1; t.aa = 2; t.da = 16'h0042; drive(t);
        check("single wbCount", 16'(wbCount_o), 16'd1);
        for (int i = 0; i < 127; i++) dual_wb(i);
        check("wbCount 255", 16'(wbCount_o), 16'd255);
        dual_wb(200);
        check("wbCount 255+2", 16'(wbCount_o), 16'd1);
        t = blank(); drive(t);
        check("wbCount hold", 16'(wbCount_o), 16'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
